alu_arbiter: RTL and testbench

- Shares the single registered ALU between two requesters: requester 0 is the pipeline execute stage and requester 1 is the address-generation/debug port.
- Arbitrates per cycle using round-robin or fixed priority, and drives the granted operand set into the ALU inputs.
- Tracks the one ALU op in flight during the ALU's 1-cycle latency.
- Captures each result into a 2-entry response FIFO and returns it with the requester id and tag under valid/ready backpressure.

---
 rtl/alu_arbiter.sv | 158 +++++++++++++++
 tb/tb_alu_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for the shared registered ALU. It picks one requester per cycle,
// tracks the op in flight for one cycle, and returns results through a 2-entry response FIFO.
module alu_arbiter #(
  parameter int TAG_W      = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_valid,
  input  logic             r1_valid,
  output logic             r0_ready,
  output logic             r1_ready,
  input  logic [5:0]       r0_opcode,
  input  logic [5:0]       r1_opcode,
  input  logic [31:0]      r0_rrs,
  input  logic [31:0]      r1_rrs,
  input  logic [31:0]      r0_rrt,
  input  logic [31:0]      r1_rrt,
  input  logic [15:0]      r0_imm,
  input  logic [15:0]      r1_imm,
  input  logic [5:0]       r0_funct,
  input  logic [5:0]       r1_funct,
  input  logic [4:0]       r0_shamt,
  input  logic [4:0]       r1_shamt,
  input  logic [TAG_W-1:0] r0_tag,
  input  logic [TAG_W-1:0] r1_tag,
  output logic [5:0]       alu_opcode,
  output logic [31:0]      alu_rrs,
  output logic [31:0]      alu_rrt,
  output logic [15:0]      alu_imm,
  output logic [5:0]       alu_funct,
  output logic [4:0]       alu_shamt,
  input  logic [31:0]      alu_rslt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_rslt
);

  localparam logic FIXED = (FIXED_PRIO != 0);

  logic [1:0]       fifo_cnt;
  logic             s1_vld;
  logic             s1_id;
  logic [TAG_W-1:0] s1_tag;
  logic             last;

  logic             tail_id;
  logic [TAG_W-1:0] tail_tag;
  logic [31:0]      tail_rslt;

  logic             pop;
  logic [2:0]       occupancy;
  logic             allow;
  logic             r0_wins;
  logic             gnt0;
  logic             gnt1;

  assign rsp_valid = (fifo_cnt != 2'd0);
  assign pop       = rsp_valid & rsp_ready;

  // Counting the in-flight op as occupied guarantees a FIFO slot exists when its result lands.
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, s1_vld} - {2'b00, pop};
  assign allow     = (occupancy < 3'd2) & ~rst;
  assign r0_wins   = FIXED | last;
  assign gnt0      = allow & r0_valid & (~r1_valid | r0_wins);
  assign gnt1      = allow & r1_valid & (~r0_valid | ~r0_wins);
  assign r0_ready  = gnt0;
  assign r1_ready  = gnt1;

  always_comb begin
    alu_opcode = '0;
    alu_rrs    = '0;
    alu_rrt    = '0;
    alu_imm    = '0;
    alu_funct  = '0;
    alu_shamt  = '0;
    if (gnt0) begin
      alu_opcode = r0_opcode;
      alu_rrs    = r0_rrs;
      alu_rrt    = r0_rrt;
      alu_imm    = r0_imm;
      alu_funct  = r0_funct;
      alu_shamt  = r0_shamt;
    end else if (gnt1) begin
      alu_opcode = r1_opcode;
      alu_rrs    = r1_rrs;
      alu_rrt    = r1_rrt;
      alu_imm    = r1_imm;
      alu_funct  = r1_funct;
      alu_shamt  = r1_shamt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_id     <= 1'b0;
      s1_tag    <= '0;
      last      <= 1'b1;
      fifo_cnt  <= 2'd0;
      rsp_id    <= 1'b0;
      rsp_tag   <= '0;
      rsp_rslt  <= '0;
      tail_id   <= 1'b0;
      tail_tag  <= '0;
      tail_rslt <= '0;
    end else begin
      s1_vld <= gnt0 | gnt1;
      if (gnt0 | gnt1) begin
        s1_id  <= gnt1;
        s1_tag <= gnt1 ? r1_tag : r0_tag;
        last   <= gnt1;
      end
      // Head slot is always the oldest entry; a pop shifts the tail forward.
      case ({s1_vld, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            rsp_id   <= s1_id;
            rsp_tag  <= s1_tag;
            rsp_rslt <= alu_rslt;
          end else begin
            tail_id   <= s1_id;
            tail_tag  <= s1_tag;
            tail_rslt <= alu_rslt;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          rsp_id   <= tail_id;
          rsp_tag  <= tail_tag;
          rsp_rslt <= tail_rslt;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            rsp_id   <= s1_id;
            rsp_tag  <= s1_tag;
            rsp_rslt <= alu_rslt;
          end else begin
            rsp_id    <= tail_id;
            rsp_tag   <= tail_tag;
            rsp_rslt  <= tail_rslt;
            tail_id   <= s1_id;
            tail_tag  <= s1_tag;
            tail_rslt <= alu_rslt;
          end
        end
        default: ;
      endcase
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(s1_vld && (fifo_cnt == 2'd2) && !pop));

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural registered ALU stands in for the real one,
// expected results are queued at issue and compared as responses leave the FIFO.
module tb_alu_arbiter;

  typedef struct {
    logic        id;
    logic [3:0]  tag;
    logic [31:0] rslt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0_valid = 0, r1_valid = 0;
  logic        r0_ready, r1_ready;
  logic [5:0]  r0_opcode = 0, r1_opcode = 0;
  logic [31:0] r0_rrs = 0, r1_rrs = 0, r0_rrt = 0, r1_rrt = 0;
  logic [15:0] r0_imm = 0, r1_imm = 0;
  logic [5:0]  r0_funct = 0, r1_funct = 0;
  logic [4:0]  r0_shamt = 0, r1_shamt = 0;
  logic [3:0]  r0_tag = 0, r1_tag = 0;
  logic [5:0]  alu_opcode;
  logic [31:0] alu_rrs, alu_rrt;
  logic [15:0] alu_imm;
  logic [5:0]  alu_funct;
  logic [4:0]  alu_shamt;
  logic [31:0] alu_rslt;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id;
  logic [3:0]  rsp_tag;
  logic [31:0] rsp_rslt;

  logic        fp_r0_ready, fp_r1_ready, fp_rsp_valid, fp_rsp_id;
  logic [5:0]  fp_alu_opcode, fp_alu_funct;
  logic [31:0] fp_alu_rrs, fp_alu_rrt, fp_rsp_rslt;
  logic [15:0] fp_alu_imm;
  logic [4:0]  fp_alu_shamt;
  logic [3:0]  fp_rsp_tag;

  exp_t sb_q[$];
  int   check_cnt = 0;
  int   pass_cnt  = 0;
  int   rsp_seen  = 0;
  int   base;

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(4), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r1_valid(r1_valid), .r0_ready(r0_ready), .r1_ready(r1_ready),
    .r0_opcode(r0_opcode), .r1_opcode(r1_opcode), .r0_rrs(r0_rrs), .r1_rrs(r1_rrs),
    .r0_rrt(r0_rrt), .r1_rrt(r1_rrt), .r0_imm(r0_imm), .r1_imm(r1_imm),
    .r0_funct(r0_funct), .r1_funct(r1_funct), .r0_shamt(r0_shamt), .r1_shamt(r1_shamt),
    .r0_tag(r0_tag), .r1_tag(r1_tag),
    .alu_opcode(alu_opcode), .alu_rrs(alu_rrs), .alu_rrt(alu_rrt), .alu_imm(alu_imm),
    .alu_funct(alu_funct), .alu_shamt(alu_shamt), .alu_rslt(alu_rslt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_rslt(rsp_rslt)
  );

  alu_arbiter #(.TAG_W(4), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r1_valid(r1_valid), .r0_ready(fp_r0_ready), .r1_ready(fp_r1_ready),
    .r0_opcode(r0_opcode), .r1_opcode(r1_opcode), .r0_rrs(r0_rrs), .r1_rrs(r1_rrs),
    .r0_rrt(r0_rrt), .r1_rrt(r1_rrt), .r0_imm(r0_imm), .r1_imm(r1_imm),
    .r0_funct(r0_funct), .r1_funct(r1_funct), .r0_shamt(r0_shamt), .r1_shamt(r1_shamt),
    .r0_tag(r0_tag), .r1_tag(r1_tag),
    .alu_opcode(fp_alu_opcode), .alu_rrs(fp_alu_rrs), .alu_rrt(fp_alu_rrt),
    .alu_imm(fp_alu_imm), .alu_funct(fp_alu_funct), .alu_shamt(fp_alu_shamt),
    .alu_rslt(32'd0),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_tag(fp_rsp_tag), .rsp_rslt(fp_rsp_rslt)
  );

  function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [15:0] imm,
                                          input logic [5:0] fn, input logic [4:0] sh);
    case (op)
      6'h00: begin
        case (fn)
          6'h00:        return rt << sh;
          6'h21:        return rs + rt;
          6'h22, 6'h23: return rs - rt;
          6'h25:        return rs | rt;
          default:      return 32'd0;
        endcase
      end
      6'h09:   return rs + {{16{imm[15]}}, imm};
      6'h0D:   return rs | {16'd0, imm};
      default: return 32'd0;
    endcase
  endfunction

  // Registered ALU model: result appears one cycle after the operands.
  always_ff @(posedge clk)
    alu_rslt <= ref_alu(alu_opcode, alu_rrs, alu_rrt, alu_imm, alu_funct, alu_shamt);

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, obs, exp);
  endtask

  task automatic applyStimulus(input logic v0, input logic v1, input logic rdy);
    r0_valid  = v0;
    r1_valid  = v1;
    rsp_ready = rdy;
    #1;
  endtask

  // Records issues and retires responses for the current cycle, then moves to the next one.
  task automatic advance();
    exp_t e;
    checkOutput("one_grant", {31'd0, r0_ready & r1_ready}, 32'd0);
    checkOutput("ready_needs_valid", {31'd0, (r0_ready & ~r0_valid) | (r1_ready & ~r1_valid)}, 32'd0);
    if (r0_valid && r0_ready) begin
      e.id = 1'b0; e.tag = r0_tag;
      e.rslt = ref_alu(r0_opcode, r0_rrs, r0_rrt, r0_imm, r0_funct, r0_shamt);
      sb_q.push_back(e);
    end
    if (r1_valid && r1_ready) begin
      e.id = 1'b1; e.tag = r1_tag;
      e.rslt = ref_alu(r1_opcode, r1_rrs, r1_rrt, r1_imm, r1_funct, r1_shamt);
      sb_q.push_back(e);
    end
    if (rsp_valid && rsp_ready) begin
      rsp_seen++;
      if (sb_q.size() == 0) checkOutput("sb_unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
      else begin
        e = sb_q.pop_front();
        checkOutput("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
        checkOutput("rsp_tag", {28'd0, rsp_tag}, {28'd0, e.tag});
        checkOutput("rsp_rslt", rsp_rslt, e.rslt);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(0, 0, 1);
      advance();
    end
  endtask

  initial begin
    @(negedge clk);
    r0_opcode = 6'h09; r0_rrs = 32'd5; r0_imm = 16'hFFFF; r0_tag = 4'd3;
    r1_opcode = 6'h0D; r1_rrs = 32'h10; r1_imm = 16'h1; r1_tag = 4'd7;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 1);
      checkOutput("rst_r0_ready", {31'd0, r0_ready}, 32'd0);
      checkOutput("rst_r1_ready", {31'd0, r1_ready}, 32'd0);
      checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      checkOutput("rst_alu_rrs", alu_rrs, 32'd0);
      if (i == 0) begin
        checkOutput("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
        checkOutput("rst_rsp_rslt", rsp_rslt, 32'd0);
      end
      advance();
    end
    rst = 1'b0;
    applyStimulus(1, 1, 1);
    checkOutput("first_grant_r0", {31'd0, r0_ready}, 32'd1);
    checkOutput("first_grant_r1", {31'd0, r1_ready}, 32'd0);
    checkOutput("first_alu_opcode", {26'd0, alu_opcode}, 32'h9);
    checkOutput("first_alu_rrs", alu_rrs, 32'd5);
    advance();
    idle(4);

    // Single ADDIU: 5 + sign-extended 0xFFFF = 4, visible two cycles after issue.
    applyStimulus(1, 0, 1);
    checkOutput("single_r0_ready", {31'd0, r0_ready}, 32'd1);
    advance();
    applyStimulus(0, 0, 1);
    checkOutput("single_lat1_no_rsp", {31'd0, rsp_valid}, 32'd0);
    advance();
    applyStimulus(0, 0, 1);
    checkOutput("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("single_rslt", rsp_rslt, 32'd4);
    checkOutput("single_id", {31'd0, rsp_id}, 32'd0);
    checkOutput("single_tag", {28'd0, rsp_tag}, 32'd3);
    advance();
    idle(2);

    rst = 1'b1;
    applyStimulus(0, 0, 1);
    advance();
    rst = 1'b0;

    // Contention: round-robin alternates starting at r0; fixed-priority copy always picks r0.
    base = rsp_seen;
    for (int i = 0; i < 4; i++) begin
      r0_opcode = 6'h00; r0_funct = 6'h21; r0_rrs = 32'(i * 10); r0_rrt = 32'd1; r0_tag = 4'(i);
      r1_opcode = 6'h00; r1_funct = 6'h22; r1_rrs = 32'd1000; r1_rrt = 32'(i); r1_tag = 4'(8 + i);
      applyStimulus(1, 1, 1);
      checkOutput("rr_r0_ready", {31'd0, r0_ready}, {31'd0, (i % 2) == 0});
      checkOutput("rr_r1_ready", {31'd0, r1_ready}, {31'd0, (i % 2) == 1});
      checkOutput("rr_rsp_valid", {31'd0, rsp_valid}, {31'd0, i >= 2});
      if (i < 3) begin
        checkOutput("fp_r0_ready", {31'd0, fp_r0_ready}, 32'd1);
        checkOutput("fp_r1_ready", {31'd0, fp_r1_ready}, 32'd0);
      end
      advance();
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 1);
      checkOutput("rr_drain_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      advance();
    end
    checkOutput("rr_rsp_count", 32'(rsp_seen - base), 32'd4);
    idle(2);

    // Backpressure: r1 streams SUB with the consumer stalled.
    base = rsp_seen;
    r1_opcode = 6'h00; r1_funct = 6'h22;
    for (int i = 0; i < 8; i++) begin
      r1_rrs = 32'(200 + i * 3); r1_rrt = 32'(i); r1_tag = 4'(i);
      if (i < 5) begin
        applyStimulus(0, 1, 0);
        checkOutput("bp_r1_ready", {31'd0, r1_ready}, {31'd0, i < 2});
      end else begin
        applyStimulus(0, 1, 1);
        checkOutput("bp_resume_ready", {31'd0, r1_ready}, 32'd1);
      end
      advance();
    end
    idle(5);
    checkOutput("bp_rsp_count", 32'(rsp_seen - base), 32'd5);

    // Reset with one entry buffered and one op in flight.
    r0_opcode = 6'h0D; r0_rrs = 32'hF0; r0_imm = 16'h0F; r0_tag = 4'd5;
    applyStimulus(1, 0, 0);
    advance();
    r0_tag = 4'd6;
    applyStimulus(1, 0, 0);
    advance();
    rst = 1'b1;
    applyStimulus(0, 0, 0);
    checkOutput("mid_fifo_holds_one", {31'd0, rsp_valid}, 32'd1);
    advance();
    sb_q.delete();
    rst = 1'b0;
    base = rsp_seen;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 1);
      checkOutput("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      advance();
    end
    r1_opcode = 6'h09; r1_rrs = 32'd100; r1_imm = 16'd23; r1_tag = 4'd9;
    applyStimulus(0, 1, 1);
    checkOutput("post_rst_issue", {31'd0, r1_ready}, 32'd1);
    advance();
    idle(4);
    checkOutput("post_rst_rsp_count", 32'(rsp_seen - base), 32'd1);
    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
